// File: rtl/tdc_event_reader.sv
// TDC channel consumer: captures timestamp/pulse-width events through the hasEvent/clear
// handshake into a FIFO and streams them out as two 32-bit beats per event.
module tdc_event_reader #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] TOT_MAX    = 32'h0001E848
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_enable,
    output logic                            o_enable_channel,
    input  logic                            i_hasEvent,
    input  logic [31:0]                     i_timestamp,
    input  logic [31:0]                     i_pulseWidth,
    output logic                            o_clear,
    output logic [31:0]                     o_data,
    output logic                            o_valid,
    output logic                            o_last,
    input  logic                            i_ready,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
    output logic [15:0]                     o_overflow_count,
    output logic                            o_tot_error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]    state;
    logic [31:0]   ts_mem [FIFO_DEPTH];
    logic [31:0]   pw_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          beat_sel;
    logic          full;
    logic          event_seen;
    logic          push;
    logic          drop;
    logic          pop;

    // Full is judged on the count before this edge, so a simultaneous pop never rescues a push.
    assign full       = (count == FULL_COUNT);
    assign event_seen = (state == ST_IDLE) && i_hasEvent;
    assign push       = event_seen && o_enable_channel && !full;
    assign drop       = event_seen && o_enable_channel && full;
    assign pop        = o_valid && i_ready && beat_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (i_hasEvent) state <= ST_CLEAR;
                ST_CLEAR: state <= ST_WAIT;
                ST_WAIT:  if (!i_hasEvent) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_enable_channel <= 1'b0;
            o_overflow_count <= 16'h0000;
            o_tot_error      <= 1'b0;
        end else begin
            o_enable_channel <= i_enable;
            if (drop && (o_overflow_count != 16'hFFFF))
                o_overflow_count <= o_overflow_count + 16'd1;
            if (push && (i_pulseWidth >= TOT_MAX))
                o_tot_error <= 1'b1;
        end
    end

    // Storage is not reset; the zeroed count alone makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            ts_mem[wr_ptr] <= i_timestamp;
            pw_mem[wr_ptr] <= i_pulseWidth;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_sel <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (o_valid && i_ready)
                beat_sel <= !beat_sel;
        end
    end

    assign o_valid      = (count != '0);
    assign o_data       = o_valid ? (beat_sel ? pw_mem[rd_ptr] : ts_mem[rd_ptr]) : 32'h0;
    assign o_last       = o_valid && beat_sel;
    assign o_clear      = (state == ST_CLEAR);
    assign o_fifo_count = count;

endmodule

// File: tb/tb_tdc_event_reader.sv
// Randomised scoreboard bench for tdc_event_reader: a driver models the TDC and predicts
// accepted beats, and an independent monitor checks every readout beat against the queue.
module tb_tdc_event_reader;

    localparam int          DEPTH   = 8;
    localparam logic [31:0] TOT_MAX = 32'h0001E848;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        o_enable_channel;
    logic        i_hasEvent = 1'b0;
    logic [31:0] i_timestamp = 32'h0;
    logic [31:0] i_pulseWidth = 32'h0;
    logic        o_clear;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_last;
    logic        i_ready = 1'b0;
    logic [3:0]  o_fifo_count;
    logic [15:0] o_overflow_count;
    logic        o_tot_error;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pushed_events = 0;
    int          pop_count = 0;
    int          pop_committed = 0;
    int          ready_mode = 0;
    logic        en_model = 1'b0;
    logic        exp_tot = 1'b0;
    logic [15:0] exp_overflow = 16'h0;

    tdc_event_reader #(.FIFO_DEPTH(DEPTH), .TOT_MAX(TOT_MAX)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_enable         (i_enable),
        .o_enable_channel (o_enable_channel),
        .i_hasEvent       (i_hasEvent),
        .i_timestamp      (i_timestamp),
        .i_pulseWidth     (i_pulseWidth),
        .o_clear          (o_clear),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .o_last           (o_last),
        .i_ready          (i_ready),
        .o_fifo_count     (o_fifo_count),
        .o_overflow_count (o_overflow_count),
        .o_tot_error      (o_tot_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Readout sink: ready pattern changes just after each edge so it is stable at the negedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       i_ready = 1'b0;
                1:       i_ready = 1'b1;
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pop_committed captures pops completed at edges before the upcoming one.
    always @(negedge clk) begin
        if (!reset) begin
            pop_committed = pop_count;
            checkOutput("valid", 32'(o_valid), 32'(exp_q.size() != 0));
            checkOutput("fifo_count", 32'(o_fifo_count), 32'((exp_q.size() + 1) / 2));
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", o_data, 32'h0);
                end else begin
                    checkOutput("beat_data", o_data, exp_q[0].data);
                    checkOutput("beat_last", 32'(o_last), 32'(exp_q[0].last));
                    if (i_ready) begin
                        if (exp_q[0].last)
                            pop_count++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic clearModel();
        exp_q.delete();
        pushed_events = 0;
        pop_count     = 0;
        pop_committed = 0;
        exp_overflow  = 16'h0;
        exp_tot       = 1'b0;
        en_model      = 1'b0;
    endtask

    task automatic doReset(input int cycles, input bit immediate);
        if (!immediate)
            @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        clearModel();
        @(negedge clk);
        checkOutput("rst_enable", 32'(o_enable_channel), 32'h0);
        checkOutput("rst_clear", 32'(o_clear), 32'h0);
        checkOutput("rst_valid", 32'(o_valid), 32'h0);
        checkOutput("rst_last", 32'(o_last), 32'h0);
        checkOutput("rst_data", o_data, 32'h0);
        checkOutput("rst_count", 32'(o_fifo_count), 32'h0);
        checkOutput("rst_overflow", 32'(o_overflow_count), 32'h0);
        checkOutput("rst_tot", 32'(o_tot_error), 32'h0);
        repeat (cycles - 1) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        en_model = i_enable;
        @(negedge clk);
        checkOutput("enable_after_reset", 32'(o_enable_channel), 32'(i_enable));
    endtask

    task automatic setEnable(input logic v);
        @(negedge clk);
        i_enable = v;
        @(posedge clk);
        #1;
        en_model = v;
        @(negedge clk);
        checkOutput("enable_follow", 32'(o_enable_channel), 32'(v));
    endtask

    // One TDC event: hasEvent raised, clear expected the cycle after capture, optional extra hold.
    task automatic applyStimulus(input logic [31:0] ts, input logic [31:0] pw, input int hold);
        @(negedge clk);
        checkOutput("clear_idle", 32'(o_clear), 32'h0);
        i_hasEvent   = 1'b1;
        i_timestamp  = ts;
        i_pulseWidth = pw;
        @(posedge clk);
        #1;
        if (en_model) begin
            if (pushed_events - pop_committed < DEPTH) begin
                exp_q.push_back('{data: ts, last: 1'b0});
                exp_q.push_back('{data: pw, last: 1'b1});
                pushed_events++;
                if (pw >= TOT_MAX)
                    exp_tot = 1'b1;
            end else if (exp_overflow != 16'hFFFF) begin
                exp_overflow = exp_overflow + 16'd1;
            end
        end
        @(negedge clk);
        checkOutput("clear_pulse", 32'(o_clear), 32'h1);
        checkOutput("tot_error", 32'(o_tot_error), 32'(exp_tot));
        checkOutput("overflow_count", 32'(o_overflow_count), 32'(exp_overflow));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("clear_held", 32'(o_clear), 32'h0);
        end
        i_hasEvent = 1'b0;
        @(negedge clk);
        checkOutput("clear_done", 32'(o_clear), 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 32'(exp_q.size()), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] pw;

        i_enable = 1'b1;
        doReset(3, 1'b0);

        // Single event straight through.
        ready_mode = 1;
        applyStimulus(32'h00001234, 32'h00000050, 0);
        drain();

        // Backpressure holds the head timestamp.
        ready_mode = 0;
        applyStimulus(32'hAAAA0001, 32'h00000011, 0);
        applyStimulus(32'hAAAA0002, 32'h00000022, 0);
        repeat (10) @(negedge clk);
        checkOutput("bp_count", 32'(o_fifo_count), 32'd2);
        checkOutput("bp_data", o_data, 32'hAAAA0001);
        ready_mode = 1;
        drain();

        // Overflow: ten events into an eight-deep FIFO.
        ready_mode = 0;
        for (int i = 0; i < 10; i++)
            applyStimulus(32'h00000100 + 32'(i), 32'h00000010 + 32'(i), 0);
        checkOutput("ovf_count", 32'(o_fifo_count), 32'd8);
        checkOutput("ovf_overflow", 32'(o_overflow_count), 32'd2);
        ready_mode = 1;
        drain();

        // TOT threshold at and just below the limit.
        doReset(2, 1'b0);
        applyStimulus(32'h00000777, 32'h0001E848, 0);
        drain();
        checkOutput("tot_sticky", 32'(o_tot_error), 32'h1);
        doReset(2, 1'b0);
        applyStimulus(32'h00000778, 32'h0001E847, 0);
        drain();
        checkOutput("tot_below", 32'(o_tot_error), 32'h0);

        // Disabled channel, then a held hasEvent.
        setEnable(1'b0);
        applyStimulus(32'h0000DEAD, 32'h00000001, 0);
        checkOutput("disabled_count", 32'(o_fifo_count), 32'h0);
        setEnable(1'b1);
        ready_mode = 0;
        applyStimulus(32'h0000BEEF, 32'h00000002, 5);
        checkOutput("held_count", 32'(o_fifo_count), 32'h1);
        ready_mode = 1;
        drain();

        // Reset while the second beat is presented.
        ready_mode = 0;
        for (int i = 0; i < 3; i++)
            applyStimulus(32'h00005000 + 32'(i), 32'h00000030 + 32'(i), 0);
        ready_mode = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_last && n < 20);
        checkOutput("reach_beat1", 32'(o_last), 32'h1);
        doReset(2, 1'b1);

        // Randomised traffic with random backpressure and enable changes.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                setEnable(1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 3) == 0)
                pw = TOT_MAX + 32'($urandom_range(0, 5));
            else
                pw = 32'($urandom_range(0, 32'h0001E847));
            applyStimulus($urandom, pw, $urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        ready_mode = 1;
        drain();
        checkOutput("final_tot", 32'(o_tot_error), 32'(exp_tot));
        checkOutput("final_overflow", 32'(o_overflow_count), 32'(exp_overflow));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
